// File: rtl/bad_pixel_lut_scanner.sv
// Manual bad-pixel table matcher. Double-buffered table of raster-sorted
// {y,x} keys; each incoming pixel is compared against the next table entry
// at one pixel per clock. A head/next window plus the RAM output register
// lets the table advance one entry every cycle without bubbles.
module bad_pixel_lut_scanner #(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 10,
  parameter int DEPTH       = 256,
  parameter int ADDR_BITS   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_en,
  input  logic [ADDR_BITS:0]     cfg_num,
  input  logic                   lut_wen,
  input  logic [ADDR_BITS-1:0]   lut_waddr,
  input  logic [31:0]            lut_wdata,
  input  logic                   lut_commit,
  input  logic                   s_valid,
  input  logic                   s_sof,
  input  logic                   s_eof,
  input  logic [WIDTH_BITS-1:0]  s_x,
  input  logic [HEIGHT_BITS-1:0] s_y,
  output logic                   m_valid,
  output logic                   m_bad,
  output logic [WIDTH_BITS-1:0]  m_x,
  output logic [HEIGHT_BITS-1:0] m_y,
  output logic                   active_bank,
  output logic                   commit_pending,
  output logic [ADDR_BITS:0]     stat_hits,
  output logic [ADDR_BITS:0]     stat_skips,
  output logic                   err_overrun
);
  localparam int KW = WIDTH_BITS + HEIGHT_BITS;
  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ST_PREFETCH, ST_READY, ST_RUN} state_t;
  state_t state, state_nxt;

  logic [KW-1:0] mem [0:2*DEPTH-1];
  logic [KW-1:0] rdata, head_key, next_key, last_key, pix_key, wr_key;
  logic          head_vld, next_vld;
  logic [CW-1:0] ptr, rd_ptr, act_cnt, hit_cnt, skip_cnt, hit_inc, skip_inc;
  logic [1:0]    pf_cnt;
  logic          eval, swap, frame_end, idle_pop;
  logic          is_hit, is_stale, pop, pf_load, shift;
  logic          unused_wdata;

  assign pix_key      = {s_y, s_x};
  assign wr_key       = {lut_wdata[16+HEIGHT_BITS-1:16], lut_wdata[WIDTH_BITS-1:0]};
  assign unused_wdata = ^{lut_wdata[31:16+HEIGHT_BITS], lut_wdata[15:WIDTH_BITS]};

  // Next-state and per-cycle decision: which pixel is evaluated, frame end, swap.
  always_comb begin
    state_nxt = state;
    eval      = 1'b0;
    swap      = 1'b0;
    frame_end = 1'b0;
    idle_pop  = 1'b0;
    case (state)
      ST_PREFETCH: begin
        if (pf_cnt == 2'd2) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (lut_commit || commit_pending) begin
          swap      = 1'b1;
          state_nxt = ST_PREFETCH;
        end else if (s_valid && s_sof) begin
          eval      = 1'b1;
          state_nxt = ST_RUN;
          if (s_eof) begin
            frame_end = 1'b1;
            state_nxt = ST_PREFETCH;
          end
        end
      end
      ST_RUN: begin
        if (s_valid) begin
          eval = 1'b1;
          if (s_eof) begin
            frame_end = 1'b1;
            swap      = lut_commit || commit_pending;
            state_nxt = ST_PREFETCH;
          end
        end else begin
          // Use idle cycles to drain entries already passed by the raster.
          idle_pop = head_vld && (head_key < last_key);
        end
      end
      default: state_nxt = ST_PREFETCH;
    endcase
  end

  assign is_hit   = eval && head_vld && (head_key == pix_key);
  assign is_stale = eval && head_vld && (head_key < pix_key);
  assign pop      = is_hit || is_stale || idle_pop;
  // Prefetch cycles 1 and 2 shift the window exactly like a pop.
  assign pf_load  = (state == ST_PREFETCH) && (pf_cnt != 2'd0);
  assign shift    = pop || pf_load;
  // RAM output always holds entry 'ptr'; it advances with each shift.
  assign rd_ptr   = (state == ST_PREFETCH && pf_cnt == 2'd0) ? '0 :
                    (shift ? ptr + CW'(1) : ptr);

  assign hit_inc  = (is_hit && hit_cnt != DEPTH_C) ? hit_cnt + CW'(1) : hit_cnt;
  assign skip_inc = ((is_stale || idle_pop) && skip_cnt != DEPTH_C) ? skip_cnt + CW'(1) : skip_cnt;

  // Table RAM: writes go to the shadow bank, reads come from the active bank.
  always_ff @(posedge clk) begin
    if (lut_wen) mem[{~active_bank, lut_waddr}] <= wr_key;
    rdata <= mem[{active_bank, rd_ptr[ADDR_BITS-1:0]}];
  end

  // State, bank control and prefetch sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_PREFETCH;
      pf_cnt         <= '0;
      active_bank    <= 1'b0;
      act_cnt        <= '0;
      commit_pending <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      state  <= state_nxt;
      pf_cnt <= (state == ST_PREFETCH) ? pf_cnt + 2'd1 : 2'd0;
      if (swap) begin
        active_bank    <= ~active_bank;
        act_cnt        <= (cfg_num > DEPTH_C) ? DEPTH_C : cfg_num;
        commit_pending <= 1'b0;
      end else if (lut_commit) begin
        commit_pending <= 1'b1;
      end
      if (state == ST_PREFETCH && s_valid) err_overrun <= 1'b1;
    end
  end

  // Head/next window and read pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      head_vld <= 1'b0;
      next_vld <= 1'b0;
      head_key <= '0;
      next_key <= '0;
      last_key <= '0;
    end else begin
      if (state == ST_PREFETCH && pf_cnt == 2'd0) begin
        ptr <= '0;
      end else if (shift) begin
        ptr      <= ptr + CW'(1);
        head_key <= next_key;
        head_vld <= next_vld;
        next_key <= rdata;
        next_vld <= (ptr < act_cnt);
      end
      if (eval) last_key <= pix_key;
    end
  end

  // Per-frame statistics, latched on the eof pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt    <= '0;
      skip_cnt   <= '0;
      stat_hits  <= '0;
      stat_skips <= '0;
    end else if (frame_end) begin
      stat_hits  <= hit_inc;
      stat_skips <= skip_inc;
      hit_cnt    <= '0;
      skip_cnt   <= '0;
    end else begin
      hit_cnt    <= hit_inc;
      skip_cnt   <= skip_inc;
    end
  end

  // Registered pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_bad   <= 1'b0;
      m_x     <= '0;
      m_y     <= '0;
    end else begin
      m_valid <= s_valid;
      m_bad   <= is_hit && cfg_en;
      m_x     <= s_x;
      m_y     <= s_y;
    end
  end
endmodule

// File: tb/tb_bad_pixel_lut_scanner.sv
// Bench for bad_pixel_lut_scanner: directed table scenarios plus random
// frames, all checked each cycle against a table/index reference model.
module tb_bad_pixel_lut_scanner;
  localparam int WB = 10;
  localparam int HB = 10;
  localparam int DEPTH = 256;
  localparam int AB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_en = 1'b1;
  logic [AB:0]   cfg_num = '0;
  logic          lut_wen = 1'b0;
  logic [AB-1:0] lut_waddr = '0;
  logic [31:0]   lut_wdata = '0;
  logic          lut_commit = 1'b0;
  logic          s_valid = 1'b0, s_sof = 1'b0, s_eof = 1'b0;
  logic [WB-1:0] s_x = '0;
  logic [HB-1:0] s_y = '0;
  logic          m_valid, m_bad, active_bank, commit_pending, err_overrun;
  logic [WB-1:0] m_x;
  logic [HB-1:0] m_y;
  logic [AB:0]   stat_hits, stat_skips;

  bad_pixel_lut_scanner #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_num(cfg_num),
    .lut_wen(lut_wen), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .lut_commit(lut_commit),
    .s_valid(s_valid), .s_sof(s_sof), .s_eof(s_eof), .s_x(s_x), .s_y(s_y),
    .m_valid(m_valid), .m_bad(m_bad), .m_x(m_x), .m_y(m_y),
    .active_bank(active_bank), .commit_pending(commit_pending),
    .stat_hits(stat_hits), .stat_skips(stat_skips), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, bad_seen = 0;

  // reference model: table contents, bank, count, head index, mode
  int tbl [2][DEPTH];
  int m_md, m_pf, m_bank, m_cnt, m_pend, m_idx, m_last, m_hits, m_skips, m_sh, m_ss, m_err;
  int e_valid, e_bad, e_x, e_y;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_eval(input int key);
    int hk;
    if (m_idx < m_cnt) begin
      hk = tbl[m_bank][m_idx];
      if (hk == key) begin
        m_idx++; if (m_hits < DEPTH) m_hits++; e_bad = int'(cfg_en);
      end else if (hk < key) begin
        m_idx++; if (m_skips < DEPTH) m_skips++;
      end
    end
    m_last = key;
  endtask

  task automatic model_step();
    int key;
    bit swap, endf, go_pf;
    if (rst) begin
      m_md = 0; m_pf = 3; m_bank = 0; m_cnt = 0; m_pend = 0; m_idx = 0; m_last = 0;
      m_hits = 0; m_skips = 0; m_sh = 0; m_ss = 0; m_err = 0;
      e_valid = 0; e_bad = 0; e_x = 0; e_y = 0;
      return;
    end
    e_valid = int'(s_valid); e_x = int'(s_x); e_y = int'(s_y); e_bad = 0;
    key = int'(s_y) * 1024 + int'(s_x);
    if (lut_wen) tbl[m_bank ^ 1][int'(lut_waddr)] = int'(lut_wdata[25:16]) * 1024 + int'(lut_wdata[9:0]);
    swap = 0; endf = 0; go_pf = 0;
    case (m_md)
      0: begin
        if (s_valid) m_err = 1;
        m_pf--;
        if (m_pf == 0) m_md = 1;
      end
      1: begin
        if (lut_commit || m_pend != 0) begin swap = 1; go_pf = 1; end
        else if (s_valid && s_sof) begin m_eval(key); m_md = 2; endf = s_eof; end
      end
      default: begin
        if (s_valid) begin m_eval(key); endf = s_eof; end
        else if (m_idx < m_cnt && tbl[m_bank][m_idx] < m_last) begin
          m_idx++; if (m_skips < DEPTH) m_skips++;
        end
      end
    endcase
    if (endf) begin
      m_sh = m_hits; m_ss = m_skips; m_hits = 0; m_skips = 0;
      go_pf = 1; swap = lut_commit || m_pend != 0;
    end
    if (swap) begin
      m_bank ^= 1; m_cnt = (int'(cfg_num) > DEPTH) ? DEPTH : int'(cfg_num); m_pend = 0;
    end else if (lut_commit) m_pend = 1;
    if (go_pf) begin m_md = 0; m_pf = 3; m_idx = 0; end
  endtask

  task automatic cyc();
    bit was_rst;
    was_rst = rst;
    @(posedge clk);
    model_step();
    #1;
    chk("m_valid", int'(m_valid), e_valid);
    chk("m_bad", int'(m_bad), e_bad);
    if (e_valid != 0) begin
      chk("m_x", int'(m_x), e_x);
      chk("m_y", int'(m_y), e_y);
    end
    chk("active_bank", int'(active_bank), m_bank);
    chk("commit_pending", int'(commit_pending), m_pend);
    chk("stat_hits", int'(stat_hits), m_sh);
    chk("stat_skips", int'(stat_skips), m_ss);
    chk("err_overrun", int'(err_overrun), m_err);
    if (was_rst) begin
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_stat_hits", int'(stat_hits), 0);
    end
    if (m_bad) bad_seen++;
    rst = 1'b0; lut_wen = 1'b0; lut_commit = 1'b0;
    s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
  endtask

  task automatic blank(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input int addr, input int x, input int y);
    lut_wen = 1'b1;
    lut_waddr = AB'(addr);
    lut_wdata = {6'($urandom), 10'(y), 6'($urandom), 10'(x)};
    cyc();
  endtask

  task automatic commit_ready();
    lut_commit = 1'b1;
    cyc();
    blank(4);
  endtask

  task automatic frame(input int w, input int h, input int gap, input int commit_at, input int rst_at);
    int n;
    bit last;
    n = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        while (gap > 0 && int'($urandom_range(0, 99)) < gap) cyc();
        last = (y == h - 1) && (x == w - 1);
        s_valid = 1'b1; s_x = WB'(x); s_y = HB'(y);
        s_sof = (n == 0) || ($urandom_range(0, 59) == 0);
        s_eof = last;
        if (n == commit_at) lut_commit = 1'b1;
        if (n == rst_at) rst = 1'b1;
        cyc();
        if (n == commit_at && !last && m_md == 2) chk("pend_mid", int'(commit_pending), 1);
        n++;
      end
    end
  endtask

  task automatic load_rand(output int n);
    int lin, l;
    n = $urandom_range(0, 12);
    lin = $urandom_range(0, 6);
    for (int i = 0; i < n; i++) begin
      l = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 63)) : lin;
      wr(i, l % 16, l / 16);
      lin += $urandom_range(1, 5);
    end
    if ($urandom_range(0, 19) == 0) cfg_num = (AB+1)'($urandom_range(257, 511));
    else cfg_num = (AB+1)'(n + int'($urandom_range(0, 2)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w, h;
    // reset and fill both banks with far-away keys
    rst = 1'b1; cyc(); rst = 1'b1; cyc();
    cfg_num = '0;
    for (int i = 0; i < DEPTH; i++) wr(i, 1023, 1023);
    commit_ready();
    for (int i = 0; i < DEPTH; i++) wr(i, 1023, 1023);
    commit_ready();

    // four entries, three consecutive
    wr(0, 5, 0); wr(1, 6, 0); wr(2, 7, 0); wr(3, 2, 1);
    cfg_num = 9'd4; commit_ready();
    cfg_en = 1'b1; bad_seen = 0;
    frame(16, 2, 0, -1, -1);
    chk("t1_hits", int'(stat_hits), 4);
    chk("t1_skips", int'(stat_skips), 0);
    chk("t1_bad_cnt", bad_seen, 4);
    chk("t1_bank", int'(active_bank), 1);
    blank(3);

    // flag disabled, matching continues
    cfg_en = 1'b0; bad_seen = 0;
    frame(16, 2, 0, -1, -1);
    chk("t2_hits", int'(stat_hits), 4);
    chk("t2_bad_cnt", bad_seen, 0);
    cfg_en = 1'b1;
    blank(3);

    // stale entries after an out-of-order table
    wr(0, 9, 0); wr(1, 3, 0); wr(2, 4, 0);
    cfg_num = 9'd3; commit_ready();
    frame(16, 2, 0, -1, -1);
    chk("t3_hits", int'(stat_hits), 1);
    chk("t3_skips", int'(stat_skips), 2);
    blank(3);

    // commit mid-frame takes effect at eof
    wr(0, 0, 1); wr(1, 1, 1);
    cfg_num = 9'd2;
    frame(16, 2, 0, 5, -1);
    chk("t4_old_hits", int'(stat_hits), 1);
    chk("t4_old_skips", int'(stat_skips), 2);
    chk("t4_bank", int'(active_bank), 1);
    chk("t4_pend_clr", int'(commit_pending), 0);
    blank(3);
    frame(16, 2, 0, -1, -1);
    chk("t4_new_hits", int'(stat_hits), 2);
    blank(3);

    // empty table, then full table with an over-range count
    cfg_num = 9'd0; commit_ready();
    frame(16, 2, 0, -1, -1);
    chk("t5_zero_hits", int'(stat_hits), 0);
    blank(3);
    for (int i = 0; i < DEPTH; i++) wr(i, i % 16, i / 16);
    cfg_num = 9'd300; commit_ready();
    bad_seen = 0;
    frame(16, 16, 0, -1, -1);
    chk("t5_full_hits", int'(stat_hits), 256);
    chk("t5_full_bad", bad_seen, 256);
    chk("t5_last_bad", int'(m_bad), 1);
    blank(3);

    // pixel inside the post-eof blanking
    frame(4, 1, 0, -1, -1);
    s_valid = 1'b1; s_x = WB'(4); s_y = HB'(0);
    cyc();
    chk("t6_overrun", int'(err_overrun), 1);
    chk("t6_bad", int'(m_bad), 0);
    blank(4);

    // reset mid-frame: empty table until the next commit
    frame(16, 2, 0, -1, 10);
    chk("t7_hits", int'(stat_hits), 0);
    chk("t7_bank", int'(active_bank), 0);
    blank(3);
    bad_seen = 0;
    frame(16, 2, 0, -1, -1);
    chk("t7_nohit", int'(stat_hits), 0);
    chk("t7_nobad", bad_seen, 0);
    blank(3);

    // random frames, tables and commit timing
    for (int it = 0; it < 40; it++) begin
      cfg_en = ($urandom_range(0, 9) != 0);
      w = $urandom_range(4, 16);
      h = $urandom_range(1, 4);
      if ($urandom_range(0, 2) != 0) begin
        load_rand(n);
        if ($urandom_range(0, 1) == 0) begin
          commit_ready();
          frame(w, h, $urandom_range(0, 30), -1, -1);
        end else begin
          frame(w, h, $urandom_range(0, 30), $urandom_range(0, w * h - 1), -1);
        end
      end else begin
        frame(w, h, $urandom_range(0, 30), -1, -1);
      end
      blank(($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(3, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bad_pixel_lut_scanner.md
# bad_pixel_lut_scanner

Streaming manual bad-pixel table matcher for the DPC path: holds a double-buffered table of raster-sorted bad-pixel coordinates and flags each incoming pixel whose (x,y) matches the next table entry, at one pixel per clock. It sits beside the automatic detector, and its flag feeds the correction mux. Compared with the single-bank checker, it adds the following:
- a shadow bank with frame-aligned commit;
- a prefetch window that sustains back-to-back hits;
- stale-entry skipping;
- per-frame hit/skip statistics.

## Interface
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 10, y coordinate width
- DEPTH, 256, entries per bank
- ADDR_BITS, 8, log2(DEPTH)
- clk  in  1  single clock for all logic, LUT writes included
- rst  in  1  synchronous, active-high reset
- cfg_en  in  1  0 forces m_bad=0; matching and statistics continue
- cfg_num  in  ADDR_BITS+1  entry count for the shadow bank, latched at swap, clamped to DEPTH
- lut_wen  in  1  write strobe, always targets the shadow bank
- lut_waddr  in  ADDR_BITS  entry index
- lut_wdata  in  32  entry data: x=[WIDTH_BITS-1:0], y=[16+HEIGHT_BITS-1:16], other bits ignored
- lut_commit  in  1  pulse that requests a bank swap
- s_valid  in  1  pixel valid (no backpressure)
- s_sof  in  1  qualifies the first pixel of a frame
- s_eof  in  1  qualifies the last pixel of a frame
- s_x  in  WIDTH_BITS  pixel x
- s_y  in  HEIGHT_BITS  pixel y
- m_valid  out  1  registered s_valid
- m_bad  out  1  pixel is in the table
- m_x  out  WIDTH_BITS  registered s_x
- m_y  out  HEIGHT_BITS  registered s_y
- active_bank  out  1  bank currently matched
- commit_pending  out  1  swap requested but not yet applied
- stat_hits  out  ADDR_BITS+1  hits in the last completed frame
- stat_skips  out  ADDR_BITS+1  stale entries discarded in the last completed frame
- err_overrun  out  1  sticky; set when a pixel arrives while state is not READY/RUN

## Operation
- Storage: 2*DEPTH x (WIDTH_BITS+HEIGHT_BITS) inferred RAM with 1-cycle read latency. Bank index is the MSB of the address.
- Key = {y,x}. Comparison is unsigned on the key. The table must be raster-sorted ascending.
- Window: registers head and next, plus one read in flight. The design sustains one pop per cycle indefinitely. An entry is valid only when its pointer < active count.
- Per accepted pixel in RUN, exactly one of these applies:
  - head valid and key == pixel key: hit. Pop head, increment hit counter, m_bad = cfg_en.
  - head valid and head key < pixel key: stale. Pop head, increment skip counter, m_bad=0. At most one entry is popped per pixel.
  - otherwise: no pop, m_bad=0.
- In cycles with s_valid=0 during RUN, one stale entry (key < last accepted key) is popped per cycle.
- States:
  - PREFETCH: rewind pointer to 0, fill head and next. Takes 3 cycles, then moves to READY.
  - READY: waits for the first pixel of a frame.
    - lut_commit or commit_pending: swap immediately and go to PREFETCH.
    - s_valid&s_sof: evaluate that pixel and go to RUN.
  - RUN: evaluates pixels.
    - s_valid&s_eof: evaluate that pixel, latch stat_hits/stat_skips, clear the frame counters, swap if commit_pending, go to PREFETCH.
- Swap: toggle active_bank, latch min(cfg_num,DEPTH) as the active count, clear commit_pending.
- s_sof during RUN: the pixel is evaluated, state stays RUN, and no rewind happens (eof is the only frame boundary).
- Pixel with s_valid while in PREFETCH: m_bad=0, err_overrun is set, and the pixel is otherwise ignored.
- lut_commit in the same cycle as the swap condition counts as pending for that swap.
- Writes to the shadow bank never disturb matching.
- Counters saturate at DEPTH.

## Timing
- Reset values: state=PREFETCH, active_bank=0, active count=0, commit_pending=0. m_valid, m_bad, m_x, m_y, stat_hits, stat_skips and err_overrun are all 0.
- Latency: 1 cycle. m_* reflect the s_* sampled on the previous edge.
- Minimum blanking: 3 idle cycles between the s_eof pixel and the next s_valid.
- A commit in READY makes the new bank live 3 cycles later.

## Test plan
- After reset, write the shadow bank with (5,0),(6,0),(7,0),(2,1), cfg_num=4, commit, then wait 4 cycles. Stream a 16x2 frame -> m_bad high at those 4 pixels only (three consecutive), stat_hits=4 and stat_skips=0 after eof.
- cfg_en=0 on the same frame -> m_bad never high, stat_hits=4.
- Table (9,0),(3,0),(4,0), cfg_num=3 -> (9,0) hits. At (10,0), (3,0) is popped as stale (skips=1). At (11,0), (4,0) is popped as stale (skips=2). stat_hits=1.
- Commit during a frame with new bank content -> the current frame still uses the old entries, commit_pending=1 until eof, and the next frame uses the new entries with active_bank toggled.
- cfg_num=0 -> no hits. cfg_num=300 with DEPTH=256 -> clamped, entry 255 is still matched.
- Pixel driven 1 cycle after eof -> err_overrun=1, m_bad=0. Assert rst mid-frame -> all outputs 0 on the next cycle, no hits until a commit.
